// File: rtl/mic_alu_pkg.sv
// ---------------------------------------------------------------------------
// mic_alu_pkg
// Shared definitions for the digit-serial Mic-1 ALU (mic_alu_serial).
//   FN_*        : function encodings of the {f0,f1} select pair
//   state_t     : sequencer states IDLE -> RUN -> SHIFT -> DONE
//   alu_ctrl_t  : the six operand controls plus the two shifter controls,
//                 latched together when an operation is accepted
//   fn_code()   : extracts the {f0,f1} function code from a control word
// ---------------------------------------------------------------------------
package mic_alu_pkg;

    localparam logic [1:0] FN_AND  = 2'b00;
    localparam logic [1:0] FN_OR   = 2'b01;
    localparam logic [1:0] FN_NOTB = 2'b10;
    localparam logic [1:0] FN_SUM  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Field order matches the concatenation {f0,f1,ena,enb,inva,inc,sll8,sra1}
    typedef struct packed {
        logic f0;
        logic f1;
        logic ena;
        logic enb;
        logic inva;
        logic inc;
        logic sll8;
        logic sra1;
    } alu_ctrl_t;

    function automatic logic [1:0] fn_code(input alu_ctrl_t ctrl);
        return {ctrl.f0, ctrl.f1};
    endfunction

endpackage

// File: rtl/alu_digit.sv
// ---------------------------------------------------------------------------
// alu_digit
// Combinational DIGIT-bit slice of the Mic-1 ALU. Operands arrive already
// formed (inversion/enables applied by the caller).
//   wa, wb   in  DIGIT  formed A and B digit
//   f0, f1   in  1      function select (00 AND, 01 OR, 10 NOT B, 11 SUM)
//   cin      in  1      carry into the digit LSB (used by SUM only)
//   res      out DIGIT  digit result
//   cout     out 1      carry out of the digit MSB; 0 for logic functions
// ---------------------------------------------------------------------------
module alu_digit
    import mic_alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] wa,
    input  logic [DIGIT-1:0] wb,
    input  logic             f0,
    input  logic             f1,
    input  logic             cin,
    output logic [DIGIT-1:0] res,
    output logic             cout
);

    logic [DIGIT:0] sum;

    always_comb begin
        sum  = {1'b0, wa} + {1'b0, wb} + {{DIGIT{1'b0}}, cin};
        res  = '0;
        cout = 1'b0;
        case ({f0, f1})
            FN_AND:  res = wa & wb;
            FN_OR:   res = wa | wb;
            FN_NOTB: res = ~wb;
            default: begin
                res  = sum[DIGIT-1:0];
                cout = sum[DIGIT];
            end
        endcase
    end

endmodule

// File: rtl/mic_alu_serial.sv
// ---------------------------------------------------------------------------
// mic_alu_serial
// Digit-serial Mic-1 ALU + shifter. A WIDTH-bit operand pair is processed
// DIGIT bits per clock with the ripple carry held in a register between
// digits; the Mic-1 shifter and N/Z flags are applied after the last digit.
// Handshake: start accepted in IDLE or DONE, busy during RUN/SHIFT, done is a
// one-cycle pulse when result/flags are valid.
//   clk, rst_n                     clock, asynchronous active-low reset
//   start                          operation request
//   f0, f1                         function select (00 AND,01 OR,10 NOTB,11 SUM)
//   ena, enb, inva, inc            Mic-1 operand controls
//   sll8, sra1                     shifter controls (sll8 wins if both set)
//   a, b          [WIDTH-1:0]      operands
//   busy, done                     handshake status
//   result        [WIDTH-1:0]      shifter output
//   flag_n, flag_z                 negative / zero of the pre-shift ALU value
//   carry_out                      carry out of MSB for SUM, else 0
// ---------------------------------------------------------------------------
module mic_alu_serial
    import mic_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             f0,
    input  logic             f1,
    input  logic             ena,
    input  logic             enb,
    input  logic             inva,
    input  logic             inc,
    input  logic             sll8,
    input  logic             sra1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             carry_out
);

    localparam int NUM_DIG = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIG - 1);

    generate
        if ((DIGIT < 1) || (WIDTH < 9) ||
            (((DIGIT >= 1) ? (WIDTH % DIGIT) : 0) != 0)) begin : g_bad_params
            $error("mic_alu_serial: WIDTH must be >= 9 and a multiple of DIGIT >= 1");
        end
    endgenerate

    state_t                      state_q;
    state_t                      next_state;
    logic                        accept;

    logic [WIDTH-1:0]            a_q;
    logic [WIDTH-1:0]            b_q;
    alu_ctrl_t                   ctrl_q;
    alu_ctrl_t                   ctrl_in;
    logic [IDX_W-1:0]            idx_q;
    logic                        carry_q;
    logic [NUM_DIG-1:0][DIGIT-1:0] acc_q;

    logic [NUM_DIG-1:0][DIGIT-1:0] w_a;
    logic [NUM_DIG-1:0][DIGIT-1:0] w_b;
    logic [DIGIT-1:0]            dig_res;
    logic                        dig_cout;
    logic                        dig_cin;
    logic [WIDTH-1:0]            alu;
    logic [WIDTH-1:0]            shifted;

    assign ctrl_in = {f0, f1, ena, enb, inva, inc, sll8, sra1};

    // Operands are formed on the whole latched word; the digit mux then picks
    // the slice for the current index.
    assign w_a = (a_q & {WIDTH{ctrl_q.ena}}) ^ {WIDTH{ctrl_q.inva}};
    assign w_b = b_q & {WIDTH{ctrl_q.enb}};

    // The carry register is cleared on accept, so inc only enters at digit 0.
    assign dig_cin = carry_q | (ctrl_q.inc & (idx_q == '0));

    alu_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .wa   (w_a[idx_q]),
        .wb   (w_b[idx_q]),
        .f0   (ctrl_q.f0),
        .f1   (ctrl_q.f1),
        .cin  (dig_cin),
        .res  (dig_res),
        .cout (dig_cout)
    );

    assign alu = acc_q;

    always_comb begin
        shifted = alu;
        if (ctrl_q.sll8) begin
            shifted = {alu[WIDTH-9:0], 8'h00};
        end else if (ctrl_q.sra1) begin
            shifted = {alu[WIDTH-1], alu[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // DONE behaves like IDLE for start so back-to-back operations need no gap.
    always_comb begin
        next_state = state_q;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The index saturates on the last digit; it is only cleared by accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            acc_q     <= '0;
            result    <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                ctrl_q  <= ctrl_in;
                idx_q   <= '0;
                carry_q <= 1'b0;
            end else if (state_q == RUN) begin
                acc_q[idx_q] <= dig_res;
                carry_q      <= dig_cout;
                if (idx_q != LAST_IDX) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
            if (state_q == SHIFT) begin
                result    <= shifted;
                flag_n    <= alu[WIDTH-1];
                flag_z    <= (alu == '0);
                carry_out <= carry_q & (fn_code(ctrl_q) == FN_SUM);
            end
        end
    end

endmodule

// File: tb/tb_mic_alu_serial.sv
// ---------------------------------------------------------------------------
// tb_mic_alu_serial
// Self-checking bench for mic_alu_serial. The main instance uses WIDTH=32,
// DIGIT=8; two further instances use DIGIT=1 and DIGIT=32 for latency checks.
// Expected results are pushed to a scoreboard queue when an operation is
// started and popped by a monitor whenever the main instance pulses done.
// ---------------------------------------------------------------------------
module tb_mic_alu_serial;
    import mic_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_d1 = 1'b0;
    logic        start_d32 = 1'b0;
    logic        f0 = 1'b0, f1 = 1'b0, ena = 1'b0, enb = 1'b0;
    logic        inva = 1'b0, inc = 1'b0, sll8 = 1'b0, sra1 = 1'b0;
    logic [31:0] a = '0, b = '0;

    logic        busy, done, flag_n, flag_z, carry_out;
    logic [31:0] result;
    logic        busy_d1, done_d1, flag_n_d1, flag_z_d1, carry_out_d1;
    logic [31:0] result_d1;
    logic        busy_d32, done_d32, flag_n_d32, flag_z_d32, carry_out_d32;
    logic [31:0] result_d32;

    always #5 clk = ~clk;

    mic_alu_serial #(.WIDTH(32), .DIGIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .f0(f0), .f1(f1), .ena(ena), .enb(enb), .inva(inva), .inc(inc),
        .sll8(sll8), .sra1(sra1), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .carry_out(carry_out)
    );

    mic_alu_serial #(.WIDTH(32), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_d1),
        .f0(f0), .f1(f1), .ena(ena), .enb(enb), .inva(inva), .inc(inc),
        .sll8(sll8), .sra1(sra1), .a(a), .b(b),
        .busy(busy_d1), .done(done_d1), .result(result_d1),
        .flag_n(flag_n_d1), .flag_z(flag_z_d1), .carry_out(carry_out_d1)
    );

    mic_alu_serial #(.WIDTH(32), .DIGIT(32)) dut_d32 (
        .clk(clk), .rst_n(rst_n), .start(start_d32),
        .f0(f0), .f1(f1), .ena(ena), .enb(enb), .inva(inva), .inc(inc),
        .sll8(sll8), .sra1(sra1), .a(a), .b(b),
        .busy(busy_d32), .done(done_d32), .result(result_d32),
        .flag_n(flag_n_d32), .flag_z(flag_z_d32), .carry_out(carry_out_d32)
    );

    typedef struct {
        string       name;
        logic [1:0]  fn;
        logic [3:0]  ops;
        logic [1:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_n;
        logic        exp_z;
        logic        exp_c;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        n;
        logic        z;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // fn = {f0,f1}, ops = {ena,enb,inva,inc}, sh = {sll8,sra1}
    function automatic vec_t mkVec(input string name, input logic [1:0] fn,
                                   input logic [3:0] ops, input logic [1:0] sh,
                                   input logic [31:0] va, input logic [31:0] vb,
                                   input logic [31:0] res, input logic n,
                                   input logic z, input logic c);
        vec_t v;
        v.name = name; v.fn = fn; v.ops = ops; v.sh = sh;
        v.a = va; v.b = vb; v.exp_result = res;
        v.exp_n = n; v.exp_z = z; v.exp_c = c;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        {f0, f1}               = v.fn;
        {ena, enb, inva, inc}  = v.ops;
        {sll8, sra1}           = v.sh;
        a                      = v.a;
        b                      = v.b;
    endtask

    // Starts one operation on the main instance and returns the number of
    // clock edges from the start-sampling edge to the edge that raises done.
    // With disturb set, a second start with scrambled inputs is driven while
    // the first operation is in RUN.
    task automatic applyStimulus(input vec_t v, input bit sync, input bit disturb,
                                 output int edges);
        exp_t e;
        if (sync) @(negedge clk);
        driveInputs(v);
        start = 1'b1;
        e.name = v.name; e.result = v.exp_result;
        e.n = v.exp_n; e.z = v.exp_z; e.c = v.exp_c;
        sb.push_back(e);
        @(posedge clk);
        edges = 1;
        #1 start = 1'b0;
        while (edges < 100) begin
            @(negedge clk);
            if (done) break;
            if (disturb && edges == 2) begin
                start = 1'b1;
                a     = ~a;
                b     = 32'h1234_5678;
                f0    = ~f0;
                sll8  = ~sll8;
            end
            @(posedge clk);
            edges++;
            #1 start = 1'b0;
        end
        if (edges >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: no done within 100 edges", v.name);
        end
    endtask

    task automatic runAlt(input bit use_d1, output int edges,
                          output logic [31:0] res, output logic z);
        @(negedge clk);
        {f0, f1} = FN_SUM; {ena, enb, inva, inc} = 4'b1100; {sll8, sra1} = 2'b00;
        a = 32'h0000_00FF; b = 32'h0000_0001;
        if (use_d1) start_d1 = 1'b1; else start_d32 = 1'b1;
        @(posedge clk);
        edges = 1;
        #1 begin start_d1 = 1'b0; start_d32 = 1'b0; end
        while (edges < 100) begin
            @(negedge clk);
            if (use_d1 ? done_d1 : done_d32) break;
            @(posedge clk);
            edges++;
        end
        res = use_d1 ? result_d1 : result_d32;
        z   = use_d1 ? flag_z_d1 : flag_z_d32;
    endtask

    // Scoreboard monitor: every done pulse of the main instance must match
    // the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending op");
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, " result"}, result, e.result);
                checkOutput({e.name, " flag_n"}, {31'b0, flag_n}, {31'b0, e.n});
                checkOutput({e.name, " flag_z"}, {31'b0, flag_z}, {31'b0, e.z});
                checkOutput({e.name, " carry"}, {31'b0, carry_out}, {31'b0, e.c});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[11];
        vec_t        v;
        int          edges;
        int          done_cnt;
        logic [31:0] alt_res;
        logic        alt_z;

        vecs[0]  = mkVec("sum_ff_1",      FN_SUM,  4'b1100, 2'b00, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 0, 0, 0);
        vecs[1]  = mkVec("sum_carry_all", FN_SUM,  4'b1100, 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1, 1);
        vecs[2]  = mkVec("b_minus_a_neg", FN_SUM,  4'b1111, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFE, 1, 0, 0);
        vecs[3]  = mkVec("b_minus_a_pos", FN_SUM,  4'b1111, 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_0002, 0, 0, 1);
        vecs[4]  = mkVec("or_sll8",       FN_OR,   4'b0100, 2'b10, 32'hFFFF_0000, 32'h8000_0001, 32'h0000_0100, 1, 0, 0);
        vecs[5]  = mkVec("or_sra1",       FN_OR,   4'b0100, 2'b01, 32'hFFFF_0000, 32'h8000_0001, 32'hC000_0000, 1, 0, 0);
        vecs[6]  = mkVec("or_both_shift", FN_OR,   4'b0100, 2'b11, 32'hFFFF_0000, 32'h8000_0001, 32'h0000_0100, 1, 0, 0);
        vecs[7]  = mkVec("notb_zero",     FN_NOTB, 4'b1100, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 0);
        vecs[8]  = mkVec("and_pass",      FN_AND,  4'b1100, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0, 0);
        vecs[9]  = mkVec("sum_inc_only",  FN_SUM,  4'b0001, 2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0001, 0, 0, 0);
        vecs[10] = mkVec("and_inva_inc",  FN_AND,  4'b1111, 2'b00, 32'h0000_FFFF, 32'h1234_5678, 32'h1234_0000, 0, 0, 0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy",   {31'b0, busy},      32'd0);
        checkOutput("reset done",   {31'b0, done},      32'd0);
        checkOutput("reset result", result,             32'd0);
        checkOutput("reset carry",  {31'b0, carry_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], 1'b1, 1'b0, edges);
            checkOutput({vecs[i].name, " latency"}, 32'(edges), 32'd6);
        end

        v = mkVec("busy_start_ignored", FN_SUM, 4'b1100, 2'b00, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 0, 0, 0);
        applyStimulus(v, 1'b1, 1'b1, edges);
        checkOutput("busy_start_ignored latency", 32'(edges), 32'd6);

        v = mkVec("b2b_first", FN_SUM, 4'b1100, 2'b00, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0, 0, 0);
        applyStimulus(v, 1'b1, 1'b0, edges);
        checkOutput("b2b_first latency", 32'(edges), 32'd6);
        v = mkVec("b2b_second", FN_OR, 4'b1100, 2'b00, 32'h8000_0000, 32'h0000_00F0, 32'h8000_00F0, 1, 0, 0);
        applyStimulus(v, 1'b0, 1'b0, edges);
        checkOutput("b2b_second latency", 32'(edges), 32'd6);

        @(negedge clk);
        {f0, f1} = FN_SUM; {ena, enb, inva, inc} = 4'b1100; {sll8, sra1} = 2'b00;
        a = 32'h0000_0007; b = 32'h0000_0009;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun reset busy",   {31'b0, busy},      32'd0);
        checkOutput("midrun reset done",   {31'b0, done},      32'd0);
        checkOutput("midrun reset result", result,             32'd0);
        checkOutput("midrun reset flag_n", {31'b0, flag_n},    32'd0);
        checkOutput("midrun reset flag_z", {31'b0, flag_z},    32'd0);
        checkOutput("midrun reset carry",  {31'b0, carry_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("no done after reset", 32'(done_cnt), 32'd0);

        v = mkVec("sum_1_1_after_reset", FN_SUM, 4'b1100, 2'b00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 0, 0, 0);
        applyStimulus(v, 1'b1, 1'b0, edges);
        checkOutput("sum_1_1_after_reset latency", 32'(edges), 32'd6);

        runAlt(1'b1, edges, alt_res, alt_z);
        checkOutput("digit1 latency", 32'(edges), 32'd34);
        checkOutput("digit1 result",  alt_res,    32'h0000_0100);
        checkOutput("digit1 flag_z",  {31'b0, alt_z}, 32'd0);
        runAlt(1'b0, edges, alt_res, alt_z);
        checkOutput("digit32 latency", 32'(edges), 32'd3);
        checkOutput("digit32 result",  alt_res,    32'h0000_0100);
        checkOutput("digit32 flag_z",  {31'b0, alt_z}, 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
